sensor_multi_mef: RTL and testbench
===================================

Name: sensor_multi_mef

Overview:
Parametrised successor to the single-DHT11 request state machine. Serves N_CH sensor channels from one command port. Validates each request, runs one sensor readout with a timeout, and frames a 2-byte response onto a shared UART transmitter. Adds a periodic "continuous" monitoring mode. Sits between the command decoder (upstream) and the per-channel DHT11 readers plus uart_tx (downstream).

Parameters:
N_CH, 8, number of sensor channels (1..32)
ADDR_W, 3, channel address width, must satisfy 2**ADDR_W >= N_CH
TIMEOUT_CYC, 2500000, cycles to wait for sens_done before declaring a fault
PERIOD_CYC, 100000000, continuous-mode repeat interval in cycles (>= 2)

Ports:
clock  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_code  in  4  request code
cmd_addr  in  ADDR_W  target channel
sens_start  out  N_CH  one-hot, single-cycle readout start per channel
sens_done  in  N_CH  per-channel readout complete (level or pulse)
sens_error  in  N_CH  per-channel error flag, valid when sens_done is high
sens_temp  in  8*N_CH  packed integer temperature; channel k is at [8k+7:8k]
sens_hum  in  8*N_CH  packed integer humidity, same packing
tx_start  out  1  single-cycle pulse to uart_tx
tx_byte  out  8  byte to send, held stable from tx_start until tx_done
tx_busy  in  1  uart_tx transmitting
tx_done  in  1  uart_tx byte finished (pulse)
cont_active  out  1  continuous mode running

Behaviour:
- Reset (async, rst_n=0): state IDLE, cmd_ready=0 during reset, sens_start=0, tx_start=0, tx_byte=0x00, cont_active=0, all counters and latched command fields cleared. Reset mid-transfer aborts immediately; no partial frame resumes.
- Command codes: 0x0 status, 0x1 temperature, 0x2 humidity, 0x3 start continuous temperature, 0x4 start continuous humidity, 0x5 stop continuous. All other codes are invalid.
- Response frame is always 2 bytes: code byte, then data byte.
  - 0x00 sensor OK, data 0x00.
  - 0x1F fault (sens_error or timeout), data 0x00.
  - 0x01 temperature, data = temp.
  - 0x02 humidity, data = hum.
  - 0x0A continuous temperature stopped, data 0x00.
  - 0x0B continuous humidity stopped, data 0x00.
  - 0xFF invalid command, invalid address (cmd_addr >= N_CH), or stop while not active; data 0x00.
- States:
  - IDLE: cmd_ready=1. Handshake completes on cmd_valid & cmd_ready; code and addr are latched. Invalid command -> LOAD0 with no sensor access. Stop -> LOAD0. Otherwise -> START.
  - START: sens_start[addr]=1 for exactly one cycle -> WAIT; timeout counter cleared.
  - WAIT: on sens_done[addr]=1, capture error/temp/hum -> LOAD0. Timeout counter reaching TIMEOUT_CYC-1 with no done -> fault -> LOAD0. Other channels' done is ignored.
  - LOAD0: when tx_busy=0, drive tx_byte=code byte and pulse tx_start -> SEND0.
  - SEND0: hold tx_byte; on tx_done -> LOAD1.
  - LOAD1 / SEND1: same handshake for the data byte; on tx_done -> IDLE.
- Latency: accepted command at cycle 0 -> sens_start at cycle 1. Invalid command -> tx_start at cycle 1 if tx_busy=0.
- Continuous mode:
  - Codes 0x3/0x4 perform a normal read and reply 0x01/0x02 + data, then set cont_active=1 and latch cont_addr and cont_kind.
  - The period counter runs only while cont_active=1 and wraps at PERIOD_CYC-1, setting a pending flag.
  - When IDLE with pending=1 and cmd_valid=0, the block performs an internal read of cont_addr/cont_kind; pending clears on that start. cmd_ready=0 in that cycle.
  - cmd_valid and pending in the same IDLE cycle: the external command wins and pending stays set.
  - A second pending tick while one is already pending is merged, not queued.
  - A new 0x3/0x4 while active replaces the channel and kind and restarts the period counter.
  - 0x5 clears cont_active and pending, replies 0x0A/0x0B according to cont_kind, and resets the counter.
  - A fault during a continuous read replies 0x1F and clears cont_active.
- A single status request (0x0) never touches continuous state.

Test Plan:
- Reset, then cmd 0x1 addr 2 with sens_temp[2]=25 and done after 100 cycles -> sens_start=8'b00000100 for 1 cycle, tx bytes 0x01 then 0x19, back in IDLE with cmd_ready=1.
- cmd 0x2 addr 9 with N_CH=8 -> no sens_start, bytes 0xFF 0x00. cmd 0x7 addr 0 -> bytes 0xFF 0x00.
- cmd 0x0 addr 1 with sens_done never asserted -> after exactly TIMEOUT_CYC cycles in WAIT, bytes 0x1F 0x00.
- PERIOD_CYC=1000, cmd 0x4 addr 3 with hum=60 -> 0x02 0x3C, then one read of channel 3 every 1000 cycles. cmd 0x5 -> 0x0B 0x00, cont_active=0, no further sens_start.
- Continuous active, external cmd_valid in the same IDLE cycle as the period tick -> external command served first, then the internal read, with no tick lost and none duplicated.
- rst_n low during SEND0 with tx_busy=1 -> all outputs at reset values asynchronously. After release, cmd 0x1 is processed normally.

Source files
------------

// File: rtl/sensor_multi_mef.sv
// rtl/sensor_multi_mef.sv - multi-channel sensor request FSM with 2-byte UART reply and continuous mode
module sensor_multi_mef #(
    parameter int N_CH        = 8,
    parameter int ADDR_W      = 3,
    parameter int TIMEOUT_CYC = 2500000,
    parameter int PERIOD_CYC  = 100000000
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [3:0]           cmd_code,
    input  logic [ADDR_W-1:0]    cmd_addr,
    output logic [N_CH-1:0]      sens_start,
    input  logic [N_CH-1:0]      sens_done,
    input  logic [N_CH-1:0]      sens_error,
    input  logic [8*N_CH-1:0]    sens_temp,
    input  logic [8*N_CH-1:0]    sens_hum,
    output logic                 tx_start,
    output logic [7:0]           tx_byte,
    input  logic                 tx_busy,
    input  logic                 tx_done,
    output logic                 cont_active
);

    typedef enum logic [2:0] {IDLE, START, WAIT, LOAD0, SEND0, LOAD1, SEND1} state_t;

    state_t              state, next_state;
    logic [ADDR_W-1:0]   addr_q, cont_addr;
    logic [1:0]          op_q;
    logic                cont_req_q, internal_q, cont_kind, pending;
    logic [7:0]          resp_code, resp_data;
    logic [31:0]         tmo_cnt, per_cnt;

    logic [N_CH-1:0]     sel;
    logic                done_sel, err_sel;
    logic [7:0]          temp_sel, hum_sel;
    logic                cmd_fire, int_go, code_bad, addr_bad, is_stop, timeout, tick;
    logic [1:0]          cmd_op;

    always_comb begin
        sel      = N_CH'(1) << addr_q;
        done_sel = |(sens_done & sel);
        err_sel  = |(sens_error & sel);
        temp_sel = 8'h00;
        hum_sel  = 8'h00;
        for (int k = 0; k < N_CH; k++) begin
            if (32'(addr_q) == 32'(k)) begin
                temp_sel = sens_temp[8*k +: 8];
                hum_sel  = sens_hum[8*k +: 8];
            end
        end
    end

    // A pending periodic read steals the idle cycle only when no external command is offered
    assign cmd_ready = rst_n && (state == IDLE) && (cmd_valid || !pending);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign int_go    = (state == IDLE) && pending && !cmd_valid;
    assign code_bad  = cmd_code > 4'h5;
    assign is_stop   = cmd_code == 4'h5;
    assign addr_bad  = !(32'(cmd_addr) < 32'(N_CH));
    assign timeout   = tmo_cnt == 32'(TIMEOUT_CYC - 1);
    assign tick      = cont_active && (per_cnt == 32'(PERIOD_CYC - 1));

    always_comb begin
        case (cmd_code)
            4'h1, 4'h3: cmd_op = 2'd1;
            4'h2, 4'h4: cmd_op = 2'd2;
            default:    cmd_op = 2'd0;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        sens_start = '0;
        tx_start   = 1'b0;
        tx_byte    = 8'h00;
        case (state)
            IDLE: begin
                if (cmd_fire)
                    next_state = (code_bad || is_stop || addr_bad) ? LOAD0 : START;
                else if (int_go)
                    next_state = START;
            end
            START: begin
                sens_start = sel;
                next_state = WAIT;
            end
            WAIT:  if (done_sel || timeout) next_state = LOAD0;
            LOAD0: begin
                tx_byte = resp_code;
                if (!tx_busy) begin
                    tx_start   = 1'b1;
                    next_state = SEND0;
                end
            end
            SEND0: begin
                tx_byte = resp_code;
                if (tx_done) next_state = LOAD1;
            end
            LOAD1: begin
                tx_byte = resp_data;
                if (!tx_busy) begin
                    tx_start   = 1'b1;
                    next_state = SEND1;
                end
            end
            SEND1: begin
                tx_byte = resp_data;
                if (tx_done) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            cont_addr   <= '0;
            op_q        <= 2'd0;
            cont_req_q  <= 1'b0;
            internal_q  <= 1'b0;
            cont_kind   <= 1'b0;
            cont_active <= 1'b0;
            pending     <= 1'b0;
            resp_code   <= 8'h00;
            resp_data   <= 8'h00;
            tmo_cnt     <= '0;
            per_cnt     <= '0;
        end else begin
            if (cont_active) begin
                per_cnt <= tick ? '0 : per_cnt + 32'd1;
                if (tick) pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        addr_q     <= cmd_addr;
                        op_q       <= cmd_op;
                        cont_req_q <= (cmd_code == 4'h3) || (cmd_code == 4'h4);
                        internal_q <= 1'b0;
                        resp_data  <= 8'h00;
                        if (code_bad || (!is_stop && addr_bad)) begin
                            resp_code <= 8'hFF;
                        end else if (is_stop) begin
                            resp_code   <= cont_active ? (cont_kind ? 8'h0B : 8'h0A) : 8'hFF;
                            cont_active <= 1'b0;
                            pending     <= 1'b0;
                            per_cnt     <= '0;
                        end
                    end else if (int_go) begin
                        addr_q     <= cont_addr;
                        op_q       <= cont_kind ? 2'd2 : 2'd1;
                        cont_req_q <= 1'b0;
                        internal_q <= 1'b1;
                        pending    <= tick;
                    end
                end
                START: tmo_cnt <= '0;
                WAIT: begin
                    tmo_cnt <= tmo_cnt + 32'd1;
                    if (done_sel && !err_sel) begin
                        resp_code <= {6'd0, op_q};
                        resp_data <= (op_q == 2'd1) ? temp_sel : (op_q == 2'd2) ? hum_sel : 8'h00;
                        if (cont_req_q) begin
                            cont_active <= 1'b1;
                            cont_addr   <= addr_q;
                            cont_kind   <= op_q == 2'd2;
                            per_cnt     <= '0;
                            pending     <= 1'b0;
                        end
                    end else if (done_sel || timeout) begin
                        resp_code <= 8'h1F;
                        resp_data <= 8'h00;
                        if (cont_req_q || internal_q) begin
                            cont_active <= 1'b0;
                            pending     <= 1'b0;
                            per_cnt     <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_multi_mef.sv
// tb/tb_sensor_multi_mef.sv - scoreboard bench for sensor_multi_mef with sensor and uart models
module tb_sensor_multi_mef;
    localparam int N_CH   = 8;
    localparam int ADDR_W = 4;
    localparam int TMO    = 200;
    localparam int PER    = 1000;

    logic                clock = 1'b0;
    logic                rst_n = 1'b0;
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    logic [3:0]          cmd_code = 4'h0;
    logic [ADDR_W-1:0]   cmd_addr = '0;
    logic [N_CH-1:0]     sens_start;
    logic [N_CH-1:0]     sens_done = '0;
    logic [N_CH-1:0]     sens_error = '0;
    logic [8*N_CH-1:0]   sens_temp = '0;
    logic [8*N_CH-1:0]   sens_hum = '0;
    logic                tx_start;
    logic [7:0]          tx_byte;
    logic                tx_busy = 1'b0;
    logic                tx_done = 1'b0;
    logic                cont_active;

    sensor_multi_mef #(.N_CH(N_CH), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO), .PERIOD_CYC(PER)) dut (
        .clock(clock), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_code(cmd_code), .cmd_addr(cmd_addr), .sens_start(sens_start), .sens_done(sens_done),
        .sens_error(sens_error), .sens_temp(sens_temp), .sens_hum(sens_hum), .tx_start(tx_start),
        .tx_byte(tx_byte), .tx_busy(tx_busy), .tx_done(tx_done), .cont_active(cont_active)
    );

    always #5 clock = ~clock;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [7:0]  exp_q[$];
    int          dly[N_CH];
    logic        err[N_CH];
    int          start_cnt[N_CH];
    int          pend_ch = 0, pend_cnt = 0, busy_cnt = 0;
    logic        start_seen = 1'b0, prev_start = 1'b0;
    logic [7:0]  cur_byte = 8'h00;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // output monitor: scoreboard pop on every transmitted byte, start pulse bookkeeping
    initial forever begin
        @(negedge clock);
        if (rst_n) begin
            if (tx_start) begin
                check("tx_q_avail", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("tx_byte", 32'(tx_byte), 32'(exp_q.pop_front()));
                cur_byte   = tx_byte;
                start_seen = 1'b1;
            end else if (tx_busy) begin
                check("tx_hold", 32'(tx_byte), 32'(cur_byte));
            end
            if (sens_start != '0) begin
                check("start_onehot", $countones(sens_start), 1);
                check("start_single", 32'(prev_start), 0);
                for (int k = 0; k < N_CH; k++) begin
                    if (sens_start[k]) begin
                        start_cnt[k]++;
                        pend_ch  = k;
                        pend_cnt = dly[k];
                    end
                end
            end
            prev_start = |sens_start;
        end
    end

    // sensor and uart response models
    initial forever begin
        @(posedge clock);
        #1;
        sens_done  = '0;
        sens_error = '0;
        tx_done    = 1'b0;
        if (!rst_n) begin
            pend_cnt   = 0;
            busy_cnt   = 0;
            tx_busy    = 1'b0;
            start_seen = 1'b0;
        end else begin
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    sens_done[pend_ch]  = 1'b1;
                    sens_error[pend_ch] = err[pend_ch];
                end
            end
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    tx_busy = 1'b0;
                    tx_done = 1'b1;
                end
            end else if (start_seen) begin
                start_seen = 1'b0;
                tx_busy    = 1'b1;
                busy_cnt   = 3;
            end
        end
    end

    task automatic push2(input logic [7:0] a, input logic [7:0] b);
        exp_q.push_back(a);
        exp_q.push_back(b);
    endtask

    task automatic send_cmd(input logic [3:0] c, input int a);
        logic ok;
        @(posedge clock);
        #1;
        cmd_valid = 1'b1;
        cmd_code  = c;
        cmd_addr  = ADDR_W'(a);
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clock);
            if (cmd_ready) ok = 1'b1;
        end
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        check("accept", 32'(ok), 1);
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && cmd_ready && !tx_busy) ok = 1'b1;
        end
        check("idle_reached", 32'(ok), 1);
    endtask

    task automatic wait_start(input int ch, output int t);
        logic ok;
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < 1200 && !ok; i++) begin
            @(negedge clock);
            if (sens_start[ch]) begin
                ok = 1'b1;
                t  = cyc;
            end
        end
        check("cont_start_seen", 32'(ok), 1);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clock);
    endtask

    function automatic int total_starts();
        int s = 0;
        for (int k = 0; k < N_CH; k++) s += start_cnt[k];
        return s;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, t0, t1, s, base;
        logic ok;
        for (int k = 0; k < N_CH; k++) begin
            dly[k] = 5; err[k] = 1'b0; start_cnt[k] = 0;
        end
        sens_temp[8*2 +: 8] = 8'd25;
        sens_temp[8*5 +: 8] = 8'd30;
        sens_hum[8*3 +: 8]  = 8'd60;
        sens_hum[8*4 +: 8]  = 8'd77;

        repeat (3) @(negedge clock);
        check("rst_ready", 32'(cmd_ready), 0);
        check("rst_start", 32'(sens_start), 0);
        check("rst_txstart", 32'(tx_start), 0);
        check("rst_txbyte", 32'(tx_byte), 0);
        check("rst_cont", 32'(cont_active), 0);
        rst_n = 1'b1;

        // plain temperature read with the one-cycle start latency
        dly[2] = 100;
        push2(8'h01, 8'h19);
        send_cmd(4'h1, 2);
        @(negedge clock);
        check("t1_start", 32'(sens_start), 32'h04);
        @(negedge clock);
        check("t1_start_clr", 32'(sens_start), 0);
        wait_idle();
        check("t1_ready", 32'(cmd_ready), 1);

        // bad address and bad code answer immediately with no sensor access
        s = total_starts();
        push2(8'hFF, 8'h00);
        send_cmd(4'h2, 9);
        @(negedge clock);
        check("badaddr_txstart", 32'(tx_start), 1);
        wait_idle();
        push2(8'hFF, 8'h00);
        send_cmd(4'h7, 0);
        @(negedge clock);
        check("badcode_txstart", 32'(tx_start), 1);
        wait_idle();
        check("bad_no_start", total_starts() - s, 0);

        // timeout: TMO cycles in WAIT after the START cycle
        dly[1] = 0;
        push2(8'h1F, 8'h00);
        send_cmd(4'h0, 1);
        n = 0;
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clock);
            n++;
            if (tx_start) ok = 1'b1;
        end
        check("tmo_latency", n, TMO + 2);
        wait_idle();

        dly[6] = 7;
        err[6] = 1'b1;
        push2(8'h1F, 8'h00);
        send_cmd(4'h1, 6);
        wait_idle();

        push2(8'hFF, 8'h00);
        send_cmd(4'h5, 0);
        wait_idle();
        check("stop_idle_cont", 32'(cont_active), 0);

        // continuous humidity: periodic reads then stop
        dly[3] = 5;
        push2(8'h02, 8'h3C);
        send_cmd(4'h4, 3);
        wait_idle();
        check("cont_on", 32'(cont_active), 1);
        wait_start(3, t0);
        push2(8'h02, 8'h3C);
        wait_start(3, t1);
        push2(8'h02, 8'h3C);
        check("cont_period", t1 - t0, PER);
        wait_idle();
        push2(8'h0B, 8'h00);
        send_cmd(4'h5, 3);
        wait_idle();
        check("cont_off", 32'(cont_active), 0);
        s = total_starts();
        repeat (2500) @(negedge clock);
        check("no_start_after_stop", total_starts() - s, 0);

        // external command collides with a pending tick
        dly[5] = 4;
        push2(8'h01, 8'h1E);
        send_cmd(4'h3, 5);
        wait_idle();
        wait_start(5, t0);
        push2(8'h01, 8'h1E);
        wait_idle();
        base = start_cnt[5];
        wait_cyc(t0 + 900);
        dly[1] = 150;
        dly[4] = 3;
        push2(8'h00, 8'h00);
        push2(8'h02, 8'h4D);
        push2(8'h01, 8'h1E);
        send_cmd(4'h0, 1);
        send_cmd(4'h2, 4);
        wait_cyc(t0 + 1990);
        check("merged_tick", start_cnt[5] - base, 1);
        check("ext_served", start_cnt[4], 1);
        push2(8'h01, 8'h1E);
        wait_cyc(t0 + 2010);
        check("next_tick", start_cnt[5] - base, 2);
        wait_idle();
        push2(8'h0A, 8'h00);
        send_cmd(4'h5, 0);
        wait_idle();
        check("cont_off2", 32'(cont_active), 0);

        // asynchronous reset in SEND0 while the uart is busy
        dly[2] = 10;
        exp_q.push_back(8'h01);
        send_cmd(4'h1, 2);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clock);
            if (tx_busy) ok = 1'b1;
        end
        check("rst_busy_seen", 32'(ok), 1);
        check("send0_byte", 32'(tx_byte), 32'h01);
        #2 rst_n = 1'b0;
        #1;
        check("arst_txbyte", 32'(tx_byte), 0);
        check("arst_txstart", 32'(tx_start), 0);
        check("arst_start", 32'(sens_start), 0);
        check("arst_cont", 32'(cont_active), 0);
        check("arst_ready", 32'(cmd_ready), 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        rst_n = 1'b1;
        check("arst_q_empty", exp_q.size(), 0);
        push2(8'h01, 8'h19);
        send_cmd(4'h1, 2);
        wait_idle();
        check("post_rst_ready", 32'(cmd_ready), 1);

        repeat (10) @(negedge clock);
        check("q_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
